// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic encodings and defaults
//
// Purpose: operation encoding for the add/sub datapath and the default
// adder width used by adder_pipe_cs.
package arith_pkg;

  // Operation select: add, or subtract as A + ~B + 1.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int ADDER_WIDTH = 32;

endpackage : arith_pkg

// File: rtl/adder_cs_chunk.sv
// rtl/adder_cs_chunk.sv - combinational carry-select chunk adder
//
// Purpose: adds one CHUNK-wide slice. Both carry-in hypotheses are summed
// in parallel and the real carry-in only drives the final mux, so the
// carry path through a chunk is a single mux level.
//
// Ports:
//   a, b   CHUNK-bit operand slices
//   cin    carry into bit 0 of the slice
//   s      CHUNK-bit sum slice
//   cout   carry out of the slice MSB
//   c_msb  carry into the slice MSB (used for overflow on the top chunk)
module adder_cs_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] sum_c0;
  logic [CHUNK:0] sum_c1;
  logic [CHUNK:0] sum_sel;

  assign sum_c0  = {1'b0, a} + {1'b0, b};
  assign sum_c1  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, 1'b1};
  assign sum_sel = cin ? sum_c1 : sum_c0;

  assign s    = sum_sel[CHUNK-1:0];
  assign cout = sum_sel[CHUNK];

  // The sum bit at the MSB is a ^ b ^ carry_in, so the carry into the MSB
  // falls out of the selected sum without a separate narrower adder.
  assign c_msb = sum_sel[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule : adder_cs_chunk

// File: rtl/adder_pipe_cs.sv
// rtl/adder_pipe_cs.sv - pipelined carry-select adder/subtractor with handshakes
//
// Purpose: WIDTH-bit add/sub split into WIDTH/CHUNK chunks, one register
// stage per chunk. Stage k adds chunk k using the carry registered by
// stage k-1; operand chunks not yet consumed travel down the pipe (skew)
// alongside the partial result.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_val / in_rdy   operand handshake (transfer when both high)
//   in0, in1, sub     operands A, B and op (0: A+B, 1: A-B)
//   out_val / out_rdy result handshake (transfer when both high)
//   sum, cout, ovf    result modulo 2^WIDTH, carry out, signed overflow
//
// WIDTH must be a multiple of CHUNK.
module adder_pipe_cs
  import arith_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sub,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic              stall;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;   // valid bit entering each stage
  logic              cmsb_q;    // carry into result MSB, last stage only

  // Only a held result at the output can stall; the whole pipe then
  // freezes together so nothing overtakes or gets overwritten.
  assign stall  = valid_q[STAGES-1] && !out_rdy;
  assign in_rdy = !stall;

  assign valid_d[0] = in_val && in_rdy;
  if (STAGES > 1) begin : g_valid_chain
    assign valid_d[STAGES-1:1] = valid_q[STAGES-2:0];
  end

  // Valid bits shift every unstalled cycle, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k * CHUNK;   // operand bits still to add
    localparam int RES = (k + 1) * CHUNK;     // result bits known after stage

    logic [REM-1:0]   a_src;
    logic [REM-1:0]   b_src;
    logic             cin;
    logic [CHUNK-1:0] s_w;
    logic             cout_w;
    logic             cmsb_w;
    logic [RES-1:0]   sum_d;
    logic [RES-1:0]   sum_q;
    logic             carry_q;

    if (k == 0) begin : g_head
      op_e op;
      assign op    = op_e'(sub);
      // Subtraction is A + ~B with the +1 supplied as the first carry-in.
      assign a_src = in0;
      assign b_src = (op == OP_SUB) ? ~in1 : in1;
      assign cin   = (op == OP_SUB);
      assign sum_d = s_w;
    end else begin : g_body
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      // Skew registers belong to stage k-1's register set: they load with
      // the partial result of stage k-1 and hold the chunks above it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall && valid_d[k-1]) begin
          a_q <= g_stage[k-1].a_src[REM+CHUNK-1:CHUNK];
          b_q <= g_stage[k-1].b_src[REM+CHUNK-1:CHUNK];
        end
      end

      assign a_src = a_q;
      assign b_src = b_q;
      assign cin   = g_stage[k-1].carry_q;
      assign sum_d = {s_w, g_stage[k-1].sum_q};
    end

    adder_cs_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a     (a_src[CHUNK-1:0]),
      .b     (b_src[CHUNK-1:0]),
      .cin   (cin),
      .s     (s_w),
      .cout  (cout_w),
      .c_msb (cmsb_w)
    );

    // Data only moves with a valid token so bubbles never disturb the
    // contents of a stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (!stall && valid_d[k]) begin
        sum_q   <= sum_d;
        carry_q <= cout_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmsb_q <= 1'b0;
    end else if (!stall && valid_d[STAGES-1]) begin
      cmsb_q <= g_stage[STAGES-1].cmsb_w;
    end
  end

  assign out_val = valid_q[STAGES-1];
  assign sum     = g_stage[STAGES-1].sum_q;
  assign cout    = g_stage[STAGES-1].carry_q;
  assign ovf     = cmsb_q ^ g_stage[STAGES-1].carry_q;

endmodule : adder_pipe_cs

// File: tb/tb_adder_pipe_cs.sv
// tb/tb_adder_pipe_cs.sv - self-checking bench for adder_pipe_cs
module tb_adder_pipe_cs;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  logic clk;
  logic rst_n;

  logic        in_val, in_rdy, sub, out_val, out_rdy, cout, ovf;
  logic [31:0] in0, in1, sum;

  logic        in_val16, in_rdy16, sub16, out_val16, out_rdy16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  logic        in_val8, in_rdy8, sub8, out_val8, out_rdy8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_out = 0;
  res_t sb[$];
  int   out_cyc[$];
  res_t exp_r;

  adder_pipe_cs #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy),
    .in0(in0), .in1(in1), .sub(sub), .out_val(out_val), .out_rdy(out_rdy),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  adder_pipe_cs #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val16), .in_rdy(in_rdy16),
    .in0(a16), .in1(b16), .sub(sub16), .out_val(out_val16), .out_rdy(out_rdy16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  adder_pipe_cs #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val8), .in_rdy(in_rdy8),
    .in0(a8), .in1(b8), .sub(sub8), .out_val(out_val8), .out_rdy(out_rdy8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] bb;
    logic [32:0] full;
    res_t r;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, s};
    r.s  = full[31:0];
    r.c  = full[32];
    r.o  = (a[31] == bb[31]) && (full[31] != a[31]);
    return r;
  endfunction

  // Scoreboard monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (rst_n && out_val && out_rdy) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got sum=%h cout=%b ovf=%b, no result expected", sum, cout, ovf);
      end else begin
        exp_r = sb.pop_front();
        if ({sum, cout, ovf} !== exp_r) begin
          bad++;
          $display("FAIL sb_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                   sum, cout, ovf, exp_r.s, exp_r.c, exp_r.o);
        end
      end
      out_cyc.push_back(cyc);
      n_out++;
    end
  end

  // Drives one operation from posedge+1 until accepted; pushes its expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input res_t e);
    int  n;
    logic acc;
    in0 = a; in1 = b; sub = s; in_val = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc) begin
      @(negedge clk);
      if (in_rdy) begin
        sb.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (!acc && n > 50) begin
        total++; bad++;
        $display("FAIL send_timeout: in_rdy=%b want 1 within 50 cycles", in_rdy);
        acc = 1'b1;
      end
    end
    in_val = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_val, sum, cout, ovf} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs: got val=%b sum=%h cout=%b ovf=%b want all 0", out_val, sum, cout, ovf);
    end
    total++;
    if ({out_val16, sum16, out_val8, sum8} !== 26'd0) begin
      bad++;
      $display("FAIL reset_small: got val16=%b sum16=%h val8=%b sum8=%h want 0", out_val16, sum16, out_val8, sum8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_rdy !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_rdy: got %b want 1", in_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    in0 = 32'h0000_00FF; in1 = 32'h0000_0001; sub = 1'b0; in_val = 1'b1;
    sb.push_back('{s: 32'h0000_0100, c: 1'b0, o: 1'b0});
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      in_val = 1'b0;
      @(negedge clk);
      total++;
      if (out_val !== (i == 4)) begin
        bad++;
        $display("FAIL latency_c%0d: out_val=%b want %b", i, out_val, (i == 4));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flags();
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{s: 32'h0000_0000, c: 1'b1, o: 1'b0});
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{s: 32'h8000_0000, c: 1'b0, o: 1'b1});
    send(32'h0000_0005, 32'h0000_0007, 1'b1, '{s: 32'hFFFF_FFFE, c: 1'b0, o: 1'b0});
    send(32'h8000_0000, 32'h0000_0001, 1'b1, '{s: 32'h7FFF_FFFF, c: 1'b1, o: 1'b1});
    send(32'h1234_5678, 32'h0000_0000, 1'b1, '{s: 32'h1234_5678, c: 1'b1, o: 1'b0});
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL flags_drain: pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic        s;
    int          span;
    out_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      send(a, b, s, model(a, b, s));
    end
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    span = (out_cyc.size() == 10) ? out_cyc[9] - out_cyc[0] : -1;
    total++;
    if (sb.size() != 0 || span != 9) begin
      bad++;
      $display("FAIL b2b_stream: outputs=%0d span=%0d pending=%0d want 10 outputs span 9 pending 0",
               out_cyc.size(), span, sb.size());
    end
  endtask

  task automatic test_stall();
    int start_n;
    start_n = n_out;
    fork
      begin
        logic [31:0] a, b;
        logic        s;
        for (int i = 0; i < 10; i++) begin
          a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
          send(a, b, s, model(a, b, s));
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          total++;
          if (in_rdy !== 1'b0 || out_val !== 1'b1) begin
            bad++;
            $display("FAIL stall_hs_c%0d: in_rdy=%b out_val=%b want 0 1", i, in_rdy, out_val);
          end
          total++;
          if (sb.size() == 0 || {sum, cout, ovf} !== sb[0]) begin
            bad++;
            $display("FAIL stall_hold_c%0d: got sum=%h cout=%b ovf=%b, pending=%0d",
                     i, sum, cout, ovf, sb.size());
          end
          @(posedge clk);
        end
        #1 out_rdy = 1'b1;
      end
    join
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0 || n_out - start_n != 10) begin
      bad++;
      $display("FAIL stall_count: outputs=%0d pending=%0d want 10 0", n_out - start_n, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b0;
    send(32'd10, 32'd20, 1'b0, model(32'd10, 32'd20, 1'b0));
    send(32'd30, 32'd40, 1'b0, model(32'd30, 32'd40, 1'b0));
    send(32'd50, 32'd60, 1'b1, model(32'd50, 32'd60, 1'b1));
    @(posedge clk); #1;
    total++;
    if (out_val !== 1'b1 || in_rdy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_pre: out_val=%b in_rdy=%b want 1 0", out_val, in_rdy);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({out_val, sum, cout, ovf} !== 35'd0 || in_rdy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_async: val=%b sum=%h cout=%b ovf=%b in_rdy=%b want 0 0 0 0 1",
               out_val, sum, cout, ovf, in_rdy);
    end
    sb.delete();
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    total++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_release: in_rdy=%b out_val=%b want 1 0", in_rdy, out_val);
    end
    @(posedge clk); #1;
    in0 = 32'd3; in1 = 32'd4; sub = 1'b0; in_val = 1'b1;
    sb.push_back('{s: 32'd7, c: 1'b0, o: 1'b0});
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      in_val = 1'b0;
      @(negedge clk);
      total++;
      if (out_val !== (i == 4)) begin
        bad++;
        $display("FAIL rstmid_lat_c%0d: out_val=%b want %b", i, out_val, (i == 4));
      end
    end
    @(posedge clk); #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL rstmid_result: pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_params();
    a16 = 16'h0FFF; b16 = 16'h0001; sub16 = 1'b0; in_val16 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      in_val16 = 1'b0;
      @(negedge clk);
      total++;
      if (out_val16 !== (i == 4)) begin
        bad++;
        $display("FAIL w16_lat_c%0d: out_val=%b want %b", i, out_val16, (i == 4));
      end
    end
    total++;
    if ({sum16, cout16, ovf16} !== {16'h1000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL w16_result: got sum=%h cout=%b ovf=%b want 1000 0 0", sum16, cout16, ovf16);
    end
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h01; sub8 = 1'b1; in_val8 = 1'b1;
    @(posedge clk); #1;
    in_val8 = 1'b0;
    @(negedge clk);
    total++;
    if (out_val8 !== 1'b1 || {sum8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL w8_result: val=%b sum=%h cout=%b ovf=%b want 1 7f 1 1", out_val8, sum8, cout8, ovf8);
    end
    @(posedge clk); #1;
    total++;
    if (out_val8 !== 1'b0) begin
      bad++;
      $display("FAIL w8_drain: out_val=%b want 0", out_val8);
    end
  endtask

  initial begin
    in_val = 1'b0; in0 = '0; in1 = '0; sub = 1'b0; out_rdy = 1'b1;
    in_val16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; out_rdy16 = 1'b1;
    in_val8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; out_rdy8 = 1'b1;
    test_reset();
    test_latency();
    test_flags();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_adder_pipe_cs

// File: doc/adder_pipe_cs.md
Name: adder_pipe_cs

Overview:
Parametrised, pipelined carry-select adder/subtractor with valid/ready handshakes on both sides. It generalises the combinational 32-bit chunked carry-select adder: the data width and chunk width are configurable, there is one register stage per chunk, and it adds subtract mode, carry-out and signed-overflow flags, and backpressure. It is intended for the ALU/datapath of the TinyRV1 processor and for multi-cycle arithmetic units, where a full-width ripple between chunks limits clock frequency.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits per carry-select chunk; one pipeline stage per chunk.
STAGES, WIDTH/CHUNK, derived (localparam), pipeline depth and latency in cycles.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_val  input  1  input operands valid
in_rdy  output  1  block can accept operands this cycle
in0  input  WIDTH  operand A
in1  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B (A + ~B + 1)
out_val  output  1  result valid
out_rdy  input  1  downstream accepts result this cycle
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
ovf  output  1  signed overflow = carry-into-MSB XOR cout

Behaviour:
- Clock/reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: all stage valid bits clear; all pipeline data, carry and flag registers are 0. Hence out_val=0, sum=0, cout=0, ovf=0; in_rdy=1 once rst_n is high.
- Reset asserted mid-operation: in-flight transactions are discarded immediately; no partial result ever appears on the outputs.
- Transfer rules: input transfer when in_val && in_rdy; output transfer when out_val && out_rdy.
- Operand preparation: B' = sub ? ~in1 : in1; cin0 = sub.
- Stage k (0..STAGES-1) adds chunk k of A and B' using the carry registered by stage k-1 (cin0 for stage 0). Carry-select per chunk: both the cin=0 and cin=1 sums are formed, then muxed by the incoming carry.
- Each stage registers: the lower k+1 chunks of the result, its carry out, and the still-unprocessed upper operand chunks (skew).
- The last stage also registers carry-into-MSB, used to form ovf.
- Latency: a result accepted at edge t is presented with out_val=1 after edge t+STAGES. Throughput is one operation per cycle when out_rdy=1.
- Stall: stall = out_val && !out_rdy. in_rdy = !stall. On stall the whole pipeline holds, and sum/cout/ovf stay stable while out_val=1.
- Bubbles: a stage whose valid bit is 0 does not stall upstream. When the block is not stalled, every stage's valid bit advances each cycle, including bubbles.
- Simultaneous output transfer and input transfer in the same cycle is legal and sustains full throughput.
- in_val && !in_rdy: the input is ignored, and the source must hold its values.
- in1 = 0 with sub=1: cout=1, sum=in0. The most negative value minus 1 sets ovf=1.
- WIDTH == CHUNK is legal: one stage, one-cycle latency.

Decomposition:
- Shared package arith_pkg holds: the add/sub op encoding (OP_ADD=0, OP_SUB=1), and a default ADDER_WIDTH=32.
- Sub-module adder_cs_chunk (combinational, CHUNK-wide): inputs a, b, cin; outputs s and cout, plus carry-into-MSB for the top chunk.
- One adder_cs_chunk instance per stage, generated by a generate loop. Registers and handshake logic live in the top module.

Test Plan:
1. Default params, sub=0: 32'h0000_00FF + 32'h0000_0001 -> out_val exactly 4 cycles later, sum=32'h0000_0100, cout=0, ovf=0.
2. 32'hFFFF_FFFF + 1 -> sum=0, cout=1, ovf=0. 32'h7FFF_FFFF + 1 -> sum=32'h8000_0000, cout=0, ovf=1.
3. sub=1: 5 - 7 -> sum=32'hFFFF_FFFE, cout=0, ovf=0. 32'h8000_0000 - 1 -> sum=32'h7FFF_FFFF, cout=1, ovf=1.
4. Back-to-back stream of 10 random operations with out_rdy=1 -> 10 results on consecutive cycles, in order, matching a reference model. Then hold out_rdy=0 for 3 cycles mid-stream -> in_rdy=0, outputs stable, no loss or duplication.
5. Three operations in flight, assert rst_n=0 asynchronously between edges -> out_val=0 and sum=0 immediately. After release, in_rdy=1 and a new operation 3+4 yields 7 after 4 cycles.
6. WIDTH=16, CHUNK=4: 16'h0FFF + 16'h0001 -> 16'h1000 after 4 cycles. With WIDTH=CHUNK=8: 8'h80 - 8'h01 -> 8'h7F, ovf=1, after 1 cycle.
